seq_alu: RTL



---
 rtl/seq_alu.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-pass arithmetic/logic/shift/compare ops plus iterative
// unsigned multiply and restoring divide, behind valid/ready handshakes.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] HI
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
  logic [WIDTH-1:0] r_q;     // multiplier being consumed / quotient being built
  logic [WIDTH-1:0] r_m;     // multiplicand / divisor
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_hi;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH-1:0] w_mul_q;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_div_acc;
  logic [WIDTH-1:0] w_div_q;
  logic             w_last;

  function automatic logic [WIDTH-1:0] f_single(input logic [3:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic        [SHW-1:0]   sh;
    a_s = a;
    b_s = b;
    sh  = b[SHW-1:0];
    f_single = '0;
    case (op)
      OP_ADD:  f_single = a + b;
      OP_SUB:  f_single = a - b;
      OP_AND:  f_single = a & b;
      OP_OR:   f_single = a | b;
      OP_SRL:  f_single = a >> sh;
      OP_SRA:  f_single = a_s >>> sh;
      OP_SLL:  f_single = a << sh;
      OP_SLT:  f_single = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: f_single = {{(WIDTH-1){1'b0}}, (a < b)};
      default: f_single = '0;
    endcase
  endfunction

  // Shift-add multiply step: LSB of the multiplier selects the add, then {acc,q} >> 1.
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_mul_acc = w_mul_sum[WIDTH:1];
  assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};

  // Restoring divide step; a zero divisor always "fits", yielding all-ones / A.
  assign w_trial   = {r_acc, r_q[WIDTH-1]};
  assign w_ge      = (w_trial >= {1'b0, r_m});
  assign w_diff    = w_trial[WIDTH-1:0] - r_m;
  assign w_div_acc = w_ge ? w_diff : w_trial[WIDTH-1:0];
  assign w_div_q   = {r_q[WIDTH-2:0], w_ge};

  assign w_last = (r_cnt == CNT_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (ALUOp == OP_MULU)      w_state_nxt = S_MUL;
          else if (ALUOp == OP_DIVU) w_state_nxt = S_DIV;
          else                       w_state_nxt = S_DONE;
        end
      end
      S_MUL:   if (w_last) w_state_nxt = S_DONE;
      S_DIV:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_c   <= '0;
      r_hi  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_acc <= '0;
            r_cnt <= CNT_INIT;
            if (ALUOp == OP_MULU) begin
              r_q <= B;
              r_m <= A;
            end else if (ALUOp == OP_DIVU) begin
              r_q <= A;
              r_m <= B;
            end else begin
              r_c  <= f_single(ALUOp, A, B);
              r_hi <= '0;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_hi <= w_mul_acc;
            r_c  <= w_mul_q;
          end
        end
        S_DIV: begin
          r_acc <= w_div_acc;
          r_q   <= w_div_q;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_last) begin
            r_hi <= w_div_acc;
            r_c  <= w_div_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign C         = r_c;
  assign HI        = r_hi;

endmodule
